// File: rtl/fxp_add_scheduler.sv
// fxp_add_scheduler
// Shares one FixedPointAdder among NREQ requesters. A round-robin arbiter
// picks one request. The FSM then runs the adder's start/done handshake
// and returns the result tagged with the requester id. A timeout aborts
// the operation if the adder never answers. Per-requester sticky flags
// record adder saturation.
module fxp_add_scheduler #(
  parameter int WIDTH   = 8,
  parameter int FBITS   = 4,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 15,
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NREQ-1:0]         i_req_valid,
  output logic [NREQ-1:0]         o_req_ready,
  input  logic [NREQ*WIDTH-1:0]   i_req_a,
  input  logic [NREQ*WIDTH-1:0]   i_req_b,
  output logic                    o_add_start,
  output logic [WIDTH-1:0]        o_add_a,
  output logic [WIDTH-1:0]        o_add_b,
  input  logic                    i_add_done,
  input  logic [WIDTH-1:0]        i_add_val,
  input  logic                    i_add_overflow,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [IDW-1:0]          o_rsp_id,
  output logic [WIDTH-1:0]        o_rsp_val,
  output logic                    o_rsp_overflow,
  output logic                    o_rsp_err,
  output logic [NREQ-1:0]         o_ovf_sticky,
  input  logic [NREQ-1:0]         i_ovf_clear,
  output logic                    o_busy
);

  // Elaboration-time parameter sanity checks
  if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
    $error("fxp_add_scheduler: NREQ must be in 2..16");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("fxp_add_scheduler: TIMEOUT must be in 1..255");
  end
  if (FBITS < 0 || FBITS > WIDTH) begin : g_bad_fbits
    $error("fxp_add_scheduler: FBITS must be in 0..WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   id_q;
  logic [IDW-1:0]   grant_id;
  logic             grant_found;
  logic [WIDTH-1:0] grant_a, grant_b;
  logic [WIDTH-1:0] a_q, b_q, val_q;
  logic             ovf_q, err_q;
  logic [7:0]       cnt_q;
  logic [NREQ-1:0]  sticky_q;
  logic [NREQ-1:0]  set_mask;
  logic             accept, capture, timeout_hit;

  // Round-robin search: first valid request at or above rr_ptr, wrapping
  always_comb begin
    logic [IDW:0] idx;
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, rr_ptr_q} + (IDW+1)'(i);
      if (idx >= (IDW+1)'(NREQ)) idx = idx - (IDW+1)'(NREQ);
      if (!grant_found && i_req_valid[idx[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = idx[IDW-1:0];
      end
    end
  end

  // Operand mux for the granted requester
  always_comb begin
    grant_a = '0;
    grant_b = '0;
    for (int n = 0; n < NREQ; n++) begin
      if (grant_id == IDW'(n)) begin
        grant_a = i_req_a[n*WIDTH +: WIDTH];
        grant_b = i_req_b[n*WIDTH +: WIDTH];
      end
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and handshake strobes; reset masks ready and start
  always_comb begin
    state_d     = state_q;
    o_req_ready = '0;
    o_add_start = 1'b0;
    accept      = 1'b0;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          o_req_ready = {{(NREQ-1){1'b0}}, 1'b1} << grant_id;
          accept      = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        o_add_start = 1'b1;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (i_add_done) begin
          capture = 1'b1;
          state_d = S_RESP;
        end else if (cnt_q == 8'(TIMEOUT-1)) begin
          timeout_hit = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (i_rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (i_rst) begin
      o_req_ready = '0;
      o_add_start = 1'b0;
    end
  end

  // Operand/id capture, round-robin pointer, timeout counter and response
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_ptr_q <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      val_q    <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        a_q      <= grant_a;
        b_q      <= grant_b;
        id_q     <= grant_id;
        rr_ptr_q <= (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
      end
      if (state_q == S_ISSUE) cnt_q <= '0;
      else if (state_q == S_WAIT && !i_add_done) cnt_q <= cnt_q + 8'd1;
      if (capture) begin
        val_q <= i_add_val;
        ovf_q <= i_add_overflow;
        err_q <= 1'b0;
      end else if (timeout_hit) begin
        val_q <= '0;
        ovf_q <= 1'b0;
        err_q <= 1'b1;
      end
    end
  end

  assign set_mask = (capture && i_add_overflow) ?
                    ({{(NREQ-1){1'b0}}, 1'b1} << id_q) : '0;

  // Sticky overflow flags; a set in the same cycle as a clear wins
  always_ff @(posedge i_clk) begin
    if (i_rst) sticky_q <= '0;
    else       sticky_q <= (sticky_q & ~i_ovf_clear) | set_mask;
  end

  assign o_add_a        = a_q;
  assign o_add_b        = b_q;
  assign o_rsp_valid    = (state_q == S_RESP);
  assign o_rsp_id       = id_q;
  assign o_rsp_val      = val_q;
  assign o_rsp_overflow = ovf_q;
  assign o_rsp_err      = err_q;
  assign o_ovf_sticky   = sticky_q;
  assign o_busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_fxp_add_scheduler.sv
// Testbench for fxp_add_scheduler: a 1-cycle saturating adder model plus a
// scoreboard of expected responses filled at each accepted request.
module tb_fxp_add_scheduler;

  localparam int WIDTH   = 8;
  localparam int FBITS   = 4;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 15;
  localparam int IDW     = 2;

  logic                  i_clk = 1'b0;
  logic                  i_rst = 1'b1;
  logic [NREQ-1:0]       i_req_valid = '0;
  logic [NREQ-1:0]       o_req_ready;
  logic [NREQ*WIDTH-1:0] i_req_a = '0;
  logic [NREQ*WIDTH-1:0] i_req_b = '0;
  logic                  o_add_start;
  logic [WIDTH-1:0]      o_add_a, o_add_b;
  logic                  i_add_done;
  logic [WIDTH-1:0]      i_add_val;
  logic                  i_add_overflow;
  logic                  o_rsp_valid;
  logic                  i_rsp_ready = 1'b0;
  logic [IDW-1:0]        o_rsp_id;
  logic [WIDTH-1:0]      o_rsp_val;
  logic                  o_rsp_overflow, o_rsp_err;
  logic [NREQ-1:0]       o_ovf_sticky;
  logic [NREQ-1:0]       i_ovf_clear = '0;
  logic                  o_busy;

  logic             adder_on  = 1'b1;
  logic             mdl_done  = 1'b0;
  logic [WIDTH-1:0] mdl_val   = '0;
  logic             mdl_ovf   = 1'b0;
  logic             late_done = 1'b0;
  logic [WIDTH-1:0] late_val  = '0;
  logic             late_ovf  = 1'b0;

  logic [WIDTH-1:0] op_a [NREQ];
  logic [WIDTH-1:0] op_b [NREQ];

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] val;
    logic             ovf;
    logic             err;
  } rsp_t;

  rsp_t exp_q[$];
  int   grant_log[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  assign i_add_done     = mdl_done | late_done;
  assign i_add_val      = late_done ? late_val : mdl_val;
  assign i_add_overflow = late_done ? late_ovf : mdl_ovf;

  fxp_add_scheduler #(
    .WIDTH(WIDTH), .FBITS(FBITS), .NREQ(NREQ), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_a(i_req_a), .i_req_b(i_req_b),
    .o_add_start(o_add_start), .o_add_a(o_add_a), .o_add_b(o_add_b),
    .i_add_done(i_add_done), .i_add_val(i_add_val), .i_add_overflow(i_add_overflow),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_id(o_rsp_id), .o_rsp_val(o_rsp_val),
    .o_rsp_overflow(o_rsp_overflow), .o_rsp_err(o_rsp_err),
    .o_ovf_sticky(o_ovf_sticky), .i_ovf_clear(i_ovf_clear),
    .o_busy(o_busy)
  );

  // Free-running clock and cycle counter
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Signed saturating add: returns {overflow, value}
  function automatic logic [8:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic signed [8:0] s;
    s = $signed({a[7], a}) + $signed({b[7], b});
    if (s > 9'sd127) return {1'b1, 8'h7F};
    if (s < -9'sd128) return {1'b1, 8'h80};
    return {1'b0, s[7:0]};
  endfunction

  // Adder model: done and result one cycle after start
  always @(posedge i_clk) begin
    mdl_done <= 1'b0;
    if (adder_on && o_add_start) begin
      {mdl_ovf, mdl_val} <= sat_add(o_add_a, o_add_b);
      mdl_done <= 1'b1;
    end
  end

  // Grant monitor: logs accepted requester and pushes its expected response
  always @(negedge i_clk) begin : grant_mon
    rsp_t e;
    logic [8:0] s;
    #1;
    if (!i_rst) begin
      for (int n = 0; n < NREQ; n++) begin
        if (i_req_valid[n] && o_req_ready[n]) begin
          s    = sat_add(op_a[n], op_b[n]);
          e.id = IDW'(n);
          if (adder_on) begin
            e.val = s[7:0]; e.ovf = s[8]; e.err = 1'b0;
          end else begin
            e.val = '0; e.ovf = 1'b0; e.err = 1'b1;
          end
          exp_q.push_back(e);
          grant_log.push_back(n);
        end
      end
    end
  end

  task automatic set_ops(input int n, input logic [7:0] a, input logic [7:0] b);
    op_a[n] = a;
    op_b[n] = b;
    i_req_a[n*WIDTH +: WIDTH] = a;
    i_req_b[n*WIDTH +: WIDTH] = b;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1; i_req_valid = '0; i_rsp_ready = 1'b0;
    i_ovf_clear = '0; late_done = 1'b0; adder_on = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    exp_q.delete();
    grant_log.delete();
  endtask

  // Raise valid for requester n until it is accepted; c0 is the accept cycle
  task automatic do_op(input int n, input logic [7:0] a, input logic [7:0] b, output int c0);
    set_ops(n, a, b);
    c0 = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge i_clk);
      i_req_valid[n] = 1'b1;
      #1;
      if (o_req_ready[n]) begin
        c0 = cyc;
        break;
      end
    end
    checks++;
    if (c0 < 0) begin
      errors++;
      $display("[TB] FAIL grant_req%0d: got no grant, expected grant within 40 cycles", n);
    end
  endtask

  // Wait for a response, handshake it and compare with the scoreboard head
  task automatic wait_rsp(input string name, input int bound, output int rc);
    rsp_t e;
    rc = -1;
    for (int k = 0; k < bound; k++) begin
      @(negedge i_clk);
      i_rsp_ready = 1'b1;
      #1;
      if (o_rsp_valid) begin
        rc = cyc;
        break;
      end
    end
    checks++;
    if (rc < 0) begin
      errors++;
      $display("[TB] FAIL %s_timeout: got no response, expected one within %0d cycles", name, bound);
      return;
    end
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s_unexpected: got response id %0d, expected none", name, o_rsp_id);
      return;
    end
    e = exp_q.pop_front();
    if (o_rsp_id !== e.id) begin
      errors++;
      $display("[TB] FAIL %s_id: got %0d, expected %0d", name, o_rsp_id, e.id);
    end
    checks++;
    if (o_rsp_val !== e.val) begin
      errors++;
      $display("[TB] FAIL %s_val: got %0h, expected %0h", name, o_rsp_val, e.val);
    end
    checks++;
    if (o_rsp_overflow !== e.ovf || o_rsp_err !== e.err) begin
      errors++;
      $display("[TB] FAIL %s_flags: got ovf=%0b err=%0b, expected ovf=%0b err=%0b",
               name, o_rsp_overflow, o_rsp_err, e.ovf, e.err);
    end
  endtask

  task automatic test_reset();
    @(negedge i_clk);
    i_rst = 1'b1; i_req_valid = '1; i_rsp_ready = 1'b1;
    @(negedge i_clk);
    #1;
    checks++;
    if ({o_req_ready, o_add_start, o_add_a, o_add_b, o_rsp_valid, o_rsp_id, o_rsp_val,
         o_rsp_overflow, o_rsp_err, o_ovf_sticky, o_busy} !== 39'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got ready=%b start=%b a=%h b=%h rv=%b id=%0d val=%h ovf=%b err=%b sticky=%b busy=%b, expected all zero",
               o_req_ready, o_add_start, o_add_a, o_add_b, o_rsp_valid, o_rsp_id, o_rsp_val,
               o_rsp_overflow, o_rsp_err, o_ovf_sticky, o_busy);
    end
    i_req_valid = '0;
    i_rst = 1'b0;
  endtask

  task automatic test_basic_add();
    int c0, rc;
    do_reset();
    do_op(2, 8'h18, 8'h10, c0);
    checks++;
    if (o_req_ready !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL basic_ready: got %b, expected 0100", o_req_ready);
    end
    @(negedge i_clk);
    i_req_valid = '0;
    #1;
    checks++;
    if (o_add_start !== 1'b1 || o_add_a !== 8'h18 || o_add_b !== 8'h10) begin
      errors++;
      $display("[TB] FAIL basic_issue: got start=%b a=%h b=%h, expected start=1 a=18 b=10",
               o_add_start, o_add_a, o_add_b);
    end
    @(negedge i_clk);
    #1;
    checks++;
    if (o_add_start !== 1'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_wait: got start=%b busy=%b, expected start=0 busy=1", o_add_start, o_busy);
    end
    wait_rsp("basic", 10, rc);
    checks++;
    if (rc - c0 != 3) begin
      errors++;
      $display("[TB] FAIL basic_latency: got %0d, expected 3", rc - c0);
    end
    @(negedge i_clk);
    #1;
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_idle: got busy=%b, expected 0", o_busy);
    end
  endtask

  task automatic test_overflow_sticky();
    int c0, rc;
    do_reset();
    do_op(1, 8'h70, 8'h20, c0);
    @(negedge i_clk);
    i_req_valid = '0;
    wait_rsp("ovf", 10, rc);
    @(negedge i_clk);
    #1;
    checks++;
    if (o_ovf_sticky !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL ovf_sticky_set: got %b, expected 0010", o_ovf_sticky);
    end
    do_op(1, 8'h70, 8'h20, c0);
    @(negedge i_clk);
    i_req_valid = '0;
    i_rsp_ready = 1'b0;
    @(negedge i_clk);
    i_ovf_clear = 4'b0010;
    @(negedge i_clk);
    i_ovf_clear = '0;
    #1;
    checks++;
    if (o_ovf_sticky !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL ovf_set_wins: got %b, expected 0010", o_ovf_sticky);
    end
    wait_rsp("ovf2", 10, rc);
    @(negedge i_clk);
    i_ovf_clear = 4'b0010;
    @(negedge i_clk);
    i_ovf_clear = '0;
    #1;
    checks++;
    if (o_ovf_sticky !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL ovf_clear: got %b, expected 0000", o_ovf_sticky);
    end
  endtask

  task automatic test_round_robin();
    int rc, prev;
    int order_all[6];
    int order_odd[4];
    order_all = '{0, 1, 2, 3, 0, 1};
    order_odd = '{1, 3, 1, 3};
    do_reset();
    for (int n = 0; n < NREQ; n++) set_ops(n, 8'(n * 16 + 1), 8'h02);
    i_req_valid = 4'b1111;
    prev = -1;
    for (int k = 0; k < 6; k++) begin
      wait_rsp("rr_all", 20, rc);
      if (prev >= 0) begin
        checks++;
        if (rc - prev != 4) begin
          errors++;
          $display("[TB] FAIL rr_throughput: got %0d cycles, expected 4", rc - prev);
        end
      end
      prev = rc;
    end
    @(negedge i_clk);
    i_req_valid = '0;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (k >= grant_log.size() || grant_log[k] != order_all[k]) begin
        errors++;
        $display("[TB] FAIL rr_all_order%0d: got %0d, expected %0d", k,
                 (k < grant_log.size()) ? grant_log[k] : -1, order_all[k]);
      end
    end
    do_reset();
    i_req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) wait_rsp("rr_odd", 20, rc);
    @(negedge i_clk);
    i_req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= grant_log.size() || grant_log[k] != order_odd[k]) begin
        errors++;
        $display("[TB] FAIL rr_odd_order%0d: got %0d, expected %0d", k,
                 (k < grant_log.size()) ? grant_log[k] : -1, order_odd[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int c0, rc;
    do_reset();
    set_ops(1, 8'h11, 8'h22);
    do_op(0, 8'h05, 8'h03, c0);
    @(negedge i_clk);
    i_req_valid = 4'b0010;
    i_rsp_ready = 1'b0;
    @(negedge i_clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      #1;
      checks++;
      if (o_rsp_valid !== 1'b1 || o_rsp_id !== 2'd0 || o_rsp_val !== 8'h08 || o_rsp_err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_rsp_stable: got valid=%b id=%0d val=%h err=%b, expected valid=1 id=0 val=08 err=0",
                 o_rsp_valid, o_rsp_id, o_rsp_val, o_rsp_err);
      end
      checks++;
      if (o_req_ready !== 4'b0000 || o_add_start !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_no_grant: got ready=%b start=%b, expected ready=0000 start=0",
                 o_req_ready, o_add_start);
      end
    end
    wait_rsp("bp", 5, rc);
    checks++;
    if (o_req_ready !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL bp_hs_ready: got %b, expected 0000", o_req_ready);
    end
    @(negedge i_clk);
    #1;
    checks++;
    if (o_req_ready !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL bp_next_grant: got %b, expected 0010", o_req_ready);
    end
    @(negedge i_clk);
    i_req_valid = '0;
    wait_rsp("bp_next", 10, rc);
  endtask

  task automatic test_timeout();
    int c0, rc;
    do_reset();
    adder_on = 1'b0;
    do_op(3, 8'h01, 8'h02, c0);
    @(negedge i_clk);
    i_req_valid = '0;
    @(negedge i_clk);
    @(negedge i_clk);
    #1;
    checks++;
    if (o_add_a !== 8'h01 || o_add_b !== 8'h02 || o_rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL to_wait_hold: got a=%h b=%h rv=%b, expected a=01 b=02 rv=0",
               o_add_a, o_add_b, o_rsp_valid);
    end
    wait_rsp("timeout", 40, rc);
    checks++;
    if (rc - c0 != 2 + TIMEOUT) begin
      errors++;
      $display("[TB] FAIL to_latency: got %0d, expected %0d", rc - c0, 2 + TIMEOUT);
    end
    @(negedge i_clk);
    late_done = 1'b1; late_val = 8'h55; late_ovf = 1'b1;
    @(negedge i_clk);
    late_done = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (o_busy !== 1'b0 || o_rsp_valid !== 1'b0 || o_ovf_sticky !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL to_late_done: got busy=%b rv=%b sticky=%b, expected 0 0 0000",
                 o_busy, o_rsp_valid, o_ovf_sticky);
      end
      @(negedge i_clk);
    end
    adder_on = 1'b1;
  endtask

  task automatic test_reset_mid();
    int c0, rc;
    do_reset();
    adder_on = 1'b0;
    do_op(2, 8'h11, 8'h22, c0);
    @(negedge i_clk);
    i_req_valid = '0;
    i_rst = 1'b1;
    #1;
    checks++;
    if (o_add_start !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_issue_start: got %b, expected 0", o_add_start);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    exp_q.delete();
    do_op(2, 8'h11, 8'h22, c0);
    @(negedge i_clk);
    i_req_valid = '0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    exp_q.delete();
    i_rst = 1'b0;
    adder_on = 1'b1;
    set_ops(0, 8'h0A, 8'h14);
    i_req_valid = 4'b1111;
    #1;
    checks++;
    if ({o_add_start, o_add_a, o_add_b, o_rsp_valid, o_rsp_id, o_rsp_val,
         o_rsp_overflow, o_rsp_err, o_ovf_sticky, o_busy} !== 35'd0) begin
      errors++;
      $display("[TB] FAIL rst_mid_outputs: got start=%b a=%h b=%h rv=%b id=%0d val=%h busy=%b, expected all zero",
               o_add_start, o_add_a, o_add_b, o_rsp_valid, o_rsp_id, o_rsp_val, o_busy);
    end
    checks++;
    if (o_req_ready !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL rst_first_grant: got %b, expected 0001", o_req_ready);
    end
    @(negedge i_clk);
    i_req_valid = '0;
    wait_rsp("rst_mid", 10, rc);
  endtask

  // Test sequence
  initial begin
    for (int n = 0; n < NREQ; n++) begin
      op_a[n] = '0;
      op_b[n] = '0;
    end
    test_reset();
    test_basic_add();
    test_overflow_sticky();
    test_round_robin();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    repeat (2) @(negedge i_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the bench can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
